// File: rtl/gfx_pkg.sv
// gfx_pkg: shared Q8.8 fixed-point types, constants and saturation helper
package gfx_pkg;
   typedef logic signed [15:0] fxp16_t;
   typedef fxp16_t [15:0] mat4_t;
   localparam fxp16_t FXP_ONE = 16'h0100;
   localparam fxp16_t FXP_MAX = 16'h7FFF;
   localparam fxp16_t FXP_MIN = 16'h8000;
   typedef enum logic [1:0] {IDLE, MAC, DIV, DONE} vp_state_t;
   function automatic fxp16_t sat16(input logic signed [39:0] x);
      return x > 40'sd32767 ? FXP_MAX : x < -40'sd32768 ? FXP_MIN : fxp16_t'(x[15:0]);
   endfunction
endpackage

// File: rtl/fxp_div.sv
// fxp_div: combinational Q8.8 divide, truncating toward zero, saturating, with divide-by-zero clamp
module fxp_div import gfx_pkg::*; #(
   parameter int F = 8
) (
   input  fxp16_t i_num,
   input  fxp16_t i_den,
   output fxp16_t o_q,
   output logic   o_ovf
);
   logic signed [39:0] w_q;
   logic               w_zero;
   assign w_zero = i_den == '0;
   assign w_q    = w_zero ? 40'sd0 : (40'(i_num) <<< F) / 40'(i_den);
   assign o_q    = w_zero ? (i_num > 0 ? FXP_MAX : i_num < 0 ? FXP_MIN : '0) : sat16(w_q);
   assign o_ovf  = w_zero || 40'(o_q) != w_q;
endmodule

// File: rtl/vp_mac.sv
// vp_mac: one signed Q8.8 product per cycle into a 34-bit row accumulator with saturated row result
module vp_mac import gfx_pkg::*; #(
   parameter int F = 8
) (
   input  logic   clk,
   input  logic   rst_n,
   input  logic   i_en,
   input  logic   i_first,
   input  fxp16_t i_a,
   input  fxp16_t i_b,
   output fxp16_t o_sum,
   output logic   o_sat
);
   logic signed [31:0] w_prod;
   logic signed [33:0] w_next;
   logic signed [33:0] r_acc;
   assign w_prod = i_a * i_b;
   assign w_next = (i_first ? 34'sd0 : r_acc) + 34'(w_prod);
   assign o_sum  = sat16(40'(w_next >>> F));
   assign o_sat  = 40'(o_sum) != 40'(w_next >>> F);
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_acc <= '0;
      else if (i_en) r_acc <= w_next;
   end
endmodule

// File: rtl/vertex_project.sv
// vertex_project: 4x4 Q8.8 matrix-vertex transform followed by perspective divide
module vertex_project import gfx_pkg::*; #(
   parameter int W = 16,
   parameter int F = 8
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [15:0][W-1:0]  proj_matrix,
   input  logic [W-1:0]        vx,
   input  logic [W-1:0]        vy,
   input  logic [W-1:0]        vz,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [W-1:0]        ox,
   output logic [W-1:0]        oy,
   output logic [W-1:0]        oz,
   output logic                out_valid,
   input  logic                out_ready,
   output logic                overflow
);
   vp_state_t         r_state, w_state_nxt;
   logic [3:0]        r_cnt;
   logic [15:0][W-1:0] r_mat;
   fxp16_t            r_vx, r_vy, r_vz;
   fxp16_t            r_row [4];
   fxp16_t            r_out [3];
   logic              r_ovf;
   fxp16_t            w_mac_a, w_mac_b, w_row, w_q;
   logic              w_row_sat, w_q_ovf;
   // column 3 multiplies the implicit w = 1.0
   assign w_mac_a = r_mat[r_cnt];
   assign w_mac_b = r_cnt[1:0] == 2'd0 ? r_vx : r_cnt[1:0] == 2'd1 ? r_vy :
                    r_cnt[1:0] == 2'd2 ? r_vz : FXP_ONE;
   vp_mac #(.F(F)) u_mac (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_en    (r_state == MAC),
      .i_first (r_cnt[1:0] == 2'd0),
      .i_a     (w_mac_a),
      .i_b     (w_mac_b),
      .o_sum   (w_row),
      .o_sat   (w_row_sat)
   );
   fxp_div #(.F(F)) u_div (
      .i_num (r_row[r_cnt[1:0]]),
      .i_den (r_row[3]),
      .o_q   (w_q),
      .o_ovf (w_q_ovf)
   );
   always_comb begin
      in_ready    = r_state == IDLE;
      out_valid   = r_state == DONE;
      w_state_nxt = r_state == IDLE ? (in_valid ? MAC : IDLE) :
                    r_state == MAC  ? (r_cnt == 4'd15 ? DIV : MAC) :
                    r_state == DIV  ? (r_cnt == 4'd2 ? DONE : DIV) :
                    (out_ready ? IDLE : DONE);
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) r_state <= IDLE;
      else r_state <= w_state_nxt;
   end
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
         r_mat <= '0;
         r_vx  <= '0;
         r_vy  <= '0;
         r_vz  <= '0;
         r_row <= '{default: '0};
         r_out <= '{default: '0};
         r_ovf <= 1'b0;
      end else begin
         case (r_state)
            IDLE: if (in_valid) begin
               r_mat <= proj_matrix;
               r_vx  <= vx;
               r_vy  <= vy;
               r_vz  <= vz;
               r_cnt <= '0;
               r_ovf <= 1'b0;
            end
            MAC: begin
               r_cnt <= r_cnt + 4'd1;
               if (r_cnt[1:0] == 2'd3) begin
                  r_row[r_cnt[3:2]] <= w_row;
                  r_ovf <= r_ovf | w_row_sat;
               end
            end
            DIV: begin
               r_cnt <= r_cnt + 4'd1;
               r_out[r_cnt[1:0]] <= w_q;
               r_ovf <= r_ovf | w_q_ovf;
            end
            default: ;
         endcase
      end
   end
   assign ox       = r_out[0];
   assign oy       = r_out[1];
   assign oz       = r_out[2];
   assign overflow = r_ovf;
endmodule

// File: tb/tb_vertex_project.sv
// tb_vertex_project: directed self-checking bench for vertex_project
module tb_vertex_project;
   logic              clk = 1'b0;
   logic              rst_n = 1'b1;
   logic [15:0][15:0] proj_matrix = '0;
   logic [15:0]       vx = '0, vy = '0, vz = '0;
   logic              in_valid = 1'b0, out_ready = 1'b0;
   logic              in_ready, out_valid, overflow;
   logic [15:0]       ox, oy, oz;
   int                n_checks = 0, n_fail = 0;

   vertex_project dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .proj_matrix (proj_matrix),
      .vx          (vx),
      .vy          (vy),
      .vz          (vz),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .ox          (ox),
      .oy          (oy),
      .oz          (oz),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .overflow    (overflow)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0][15:0] ident();
      logic [15:0][15:0] m = '0;
      m[0] = 16'h0100; m[5] = 16'h0100; m[10] = 16'h0100; m[15] = 16'h0100;
      return m;
   endfunction

   // transfer one vertex, scramble inputs, return clocks until out_valid (40 = timeout)
   task automatic send(input logic [15:0][15:0] m, input logic [15:0] x, y, z, output int lat);
      proj_matrix = m; vx = x; vy = y; vz = z; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      proj_matrix = {16{16'hDEAD}}; vx = 16'h5A5A; vy = 16'hA5A5; vz = 16'h7777;
      lat = 0;
      while (!out_valid && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic accept();
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      #1 rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if ({in_ready, out_valid, overflow, ox, oy, oz} !== {3'b100, 48'h0}) begin
         n_fail++;
         $display("FAIL reset_state: got rdy/vld/ovf=%b%b%b o=%h,%h,%h want 100 o=0,0,0",
                  in_ready, out_valid, overflow, ox, oy, oz);
      end
   endtask

   task automatic test_identity();
      int lat;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL id_in_ready: got %b want 1", in_ready); end
      send(ident(), 16'h0100, 16'h0200, 16'h0300, lat);
      n_checks++;
      if (lat != 19) begin n_fail++; $display("FAIL id_latency: got %0d want 19", lat); end
      n_checks++;
      if ({ox, oy, oz, overflow} !== {16'h0100, 16'h0200, 16'h0300, 1'b0}) begin
         n_fail++;
         $display("FAIL id_result: got %h,%h,%h ovf=%b want 0100,0200,0300 ovf=0", ox, oy, oz, overflow);
      end
      n_checks++;
      if (in_ready !== 1'b0) begin n_fail++; $display("FAIL id_busy_ready: got %b want 0", in_ready); end
      accept();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL id_release: got vld/rdy=%b%b want 01", out_valid, in_ready);
      end
   endtask

   task automatic test_div_zero();
      logic [15:0][15:0] m = ident();
      int lat;
      m[15] = 16'h0000;
      send(m, 16'h0100, 16'hFF00, 16'h0000, lat);
      n_checks++;
      if (lat != 19 || {ox, oy, oz, overflow} !== {16'h7FFF, 16'h8000, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL div_zero: got lat=%0d %h,%h,%h ovf=%b want lat=19 7fff,8000,0000 ovf=1",
                  lat, ox, oy, oz, overflow);
      end
      accept();
   endtask

   task automatic test_persp();
      logic [15:0][15:0] m = ident();
      int lat;
      m[15] = 16'h0000; m[14] = 16'h0100;
      send(m, 16'h0200, 16'h0400, 16'h0200, lat);
      n_checks++;
      if (lat != 19 || {ox, oy, oz, overflow} !== {16'h0100, 16'h0200, 16'h0100, 1'b0}) begin
         n_fail++;
         $display("FAIL persp: got lat=%0d %h,%h,%h ovf=%b want lat=19 0100,0200,0100 ovf=0",
                  lat, ox, oy, oz, overflow);
      end
      accept();
   endtask

   task automatic test_saturate_hold();
      logic [15:0][15:0] m = ident();
      int lat;
      m[0] = 16'h7F00;
      send(m, 16'h7F00, 16'h0000, 16'h0000, lat);
      n_checks++;
      if (lat != 19 || {ox, oy, oz, overflow} !== {16'h7FFF, 16'h0000, 16'h0000, 1'b1}) begin
         n_fail++;
         $display("FAIL sat_result: got lat=%0d %h,%h,%h ovf=%b want lat=19 7fff,0000,0000 ovf=1",
                  lat, ox, oy, oz, overflow);
      end
      proj_matrix = ident(); vx = 16'h0100; in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1;
         n_checks++;
         if ({out_valid, in_ready, ox, oy, oz, overflow} !== {2'b10, 16'h7FFF, 32'h0, 1'b1}) begin
            n_fail++;
            $display("FAIL sat_hold%0d: got vld/rdy=%b%b %h,%h,%h ovf=%b want 10 7fff,0000,0000 ovf=1",
                     i, out_valid, in_ready, ox, oy, oz, overflow);
         end
      end
      in_valid = 1'b0;
      accept();
      n_checks++;
      if ({out_valid, in_ready} !== 2'b01) begin
         n_fail++;
         $display("FAIL sat_release: got vld/rdy=%b%b want 01", out_valid, in_ready);
      end
   endtask

   task automatic test_reset_mid();
      int lat;
      proj_matrix = ident(); vx = 16'h0100; vy = 16'h0200; vz = 16'h0300; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      repeat (8) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      n_checks++;
      if ({out_valid, in_ready, overflow, ox, oy, oz} !== {3'b010, 48'h0}) begin
         n_fail++;
         $display("FAIL mid_reset: got vld/rdy/ovf=%b%b%b o=%h,%h,%h want 010 o=0,0,0",
                  out_valid, in_ready, overflow, ox, oy, oz);
      end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready !== 1'b1) begin n_fail++; $display("FAIL mid_ready: got %b want 1", in_ready); end
      send(ident(), 16'h0080, 16'hFF80, 16'h0400, lat);
      n_checks++;
      if (lat != 19 || {ox, oy, oz, overflow} !== {16'h0080, 16'hFF80, 16'h0400, 1'b0}) begin
         n_fail++;
         $display("FAIL mid_next: got lat=%0d %h,%h,%h ovf=%b want lat=19 0080,ff80,0400 ovf=0",
                  lat, ox, oy, oz, overflow);
      end
      accept();
   endtask

   task automatic test_back_to_back();
      logic [15:0][15:0] m_a = ident();
      logic [15:0][15:0] m_b = ident();
      logic [48:0] exp_o [2];
      logic rdy;
      int cyc = 0, nt = 0, got = 0;
      int t [2] = '{0, 0};
      m_a[15] = 16'h0200;
      m_b[0] = 16'h0080; m_b[3] = 16'h0100;
      exp_o[0] = {16'h0180, 16'hFE80, 16'h0000, 1'b0};
      exp_o[1] = {16'h0280, 16'h0100, 16'hFF00, 1'b0};
      proj_matrix = m_a; vx = 16'h0300; vy = 16'hFD00; vz = 16'hFFFF;
      in_valid = 1'b1; out_ready = 1'b1;
      while (cyc < 120 && got < 2) begin
         rdy = in_ready;
         @(posedge clk); #1;
         cyc++;
         if (rdy) begin
            if (nt < 2) t[nt] = cyc;
            nt++;
            proj_matrix = m_b; vx = 16'h0300; vy = 16'h0100; vz = 16'hFF00;
         end
         if (out_valid) begin
            n_checks++;
            if ({ox, oy, oz, overflow} !== exp_o[got]) begin
               n_fail++;
               $display("FAIL b2b_result%0d: got %h,%h,%h ovf=%b want %h", got, ox, oy, oz, overflow, exp_o[got]);
            end
            got++;
         end
      end
      in_valid = 1'b0;
      @(posedge clk); #1;
      out_ready = 1'b0;
      n_checks++;
      if (got != 2) begin n_fail++; $display("FAIL b2b_count: got %0d results want 2", got); end
      n_checks++;
      if (nt < 2 || t[1] - t[0] != 21) begin
         n_fail++;
         $display("FAIL b2b_spacing: got %0d transfers spaced %0d want 2 spaced 21", nt, t[1] - t[0]);
      end
   endtask

   initial begin
      test_reset();
      test_identity();
      test_div_zero();
      test_persp();
      test_saturate_hold();
      test_reset_mid();
      test_back_to_back();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
